// File: rtl/raster_counter.sv
// Row/column/linear-index raster counter with clear and enable.
// Reusable by the line-buffer controllers that walk the same raster order.
module raster_counter #(
  parameter int unsigned COLS  = 5,
  parameter int unsigned ROWS  = 5,
  parameter int unsigned IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             first_c_o,
  output logic             last_c_o
);

  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    idx_d = idx_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
      idx_d = '0;
    end else if (en_i) begin
      idx_d = idx_q + IDX_W'(1);
      if (col_q == CW'(COLS - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      idx_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      idx_q <= idx_d;
    end
  end

  assign idx_o     = idx_q;
  assign first_c_o = (col_q == '0) && (row_q == '0);
  assign last_c_o  = (col_q == CW'(COLS - 1)) && (row_q == RW'(ROWS - 1));

endmodule

// File: rtl/feature_map_streamer.sv
// Reads a stored feature map from on-chip memory and emits it as a raster
// pixel stream (data, valid, sof/eof) for the sliding-window line buffers.
module feature_map_streamer #(
  parameter int unsigned data_width = 16,
  parameter int unsigned input_x    = 5,
  parameter int unsigned input_y    = 5,
  parameter int unsigned addr_width = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [addr_width-1:0] base_addr,
  input  logic                  stall,
  output logic                  mem_rd_en,
  output logic [addr_width-1:0] mem_addr,
  input  logic [data_width-1:0] mem_rd_data,
  output logic [data_width-1:0] data_out,
  output logic                  output_valid,
  output logic                  sof,
  output logic                  eof,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [addr_width-1:0] base_q, base_d;
  logic [addr_width-1:0] idx;
  logic                  accept_c, issue_c, first_c, last_c;
  logic                  busy_q, busy_d;
  logic                  v1_q, sof1_q, eof1_q;
  logic                  valid_q, sof_q, eof_q;
  logic [data_width-1:0] data_q;

  raster_counter #(
    .COLS  (input_x),
    .ROWS  (input_y),
    .IDX_W (addr_width)
  ) u_raster (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (accept_c),
    .en_i      (issue_c),
    .idx_o     (idx),
    .first_c_o (first_c),
    .last_c_o  (last_c)
  );

  // DRAIN leaves on the registered eof so busy stays high through the eof cycle.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    accept_c = 1'b0;
    issue_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          base_d   = base_addr;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!stall) begin
          issue_c = 1'b1;
          if (last_c) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (eof_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      busy_q  <= 1'b0;
      v1_q    <= 1'b0;
      sof1_q  <= 1'b0;
      eof1_q  <= 1'b0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      busy_q  <= busy_d;
      v1_q    <= issue_c;
      sof1_q  <= issue_c & first_c;
      eof1_q  <= issue_c & last_c;
      valid_q <= v1_q;
      sof_q   <= sof1_q;
      eof_q   <= eof1_q;
      if (v1_q) data_q <= mem_rd_data;
    end
  end

  // The read strobe is combinational so memory data lands one cycle after issue.
  assign mem_rd_en    = issue_c;
  assign mem_addr     = issue_c ? base_q + idx : '0;
  assign data_out     = data_q;
  assign output_valid = valid_q;
  assign sof          = sof_q;
  assign eof          = eof_q;
  assign done         = eof_q;
  assign busy         = busy_q;

endmodule

// File: doc/feature_map_streamer.md
Name: feature_map_streamer

Overview:
- Source side of the sliding-window line buffers: reads a stored feature map from on-chip memory and emits it as a raster pixel stream (data, valid, start-of-frame).
- Output drives the data_in / input_valid / sof inputs of a line buffer directly.
- One frame per start pulse; a pause input gates memory reads; done and busy report status.

Parameters:
- data_width, 16, pixel width in bits.
- input_x, 5, pixels per row (columns).
- input_y, 5, rows per frame.
- addr_width, 10, memory address width; must satisfy base_addr + input_x*input_y - 1 < 2^addr_width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to stream a frame; accepted only when busy=0.
- base_addr  input  addr_width  first pixel address; sampled on accepted start.
- stall  input  1  pause; while high no new memory read is issued.
- mem_rd_en  output  1  memory read strobe.
- mem_addr  output  addr_width  read address; valid when mem_rd_en=1.
- mem_rd_data  input  data_width  read data; valid exactly 1 cycle after mem_rd_en.
- data_out  output  data_width  streamed pixel.
- output_valid  output  1  data_out valid this cycle.
- sof  output  1  high with output_valid of pixel (row 0, col 0).
- eof  output  1  high with output_valid of pixel (input_y-1, input_x-1).
- busy  output  1  high from accepted start until the cycle after eof.
- done  output  1  one-cycle pulse, same cycle as eof.

Behaviour:
- Reset: all outputs 0 (data_out 0, mem_addr 0); FSM to IDLE; in-flight reads discarded; row, col and address counters cleared.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE -> ISSUE on start. Capture base_addr; row=col=0; busy=1 from the next cycle.
- ISSUE: issue = ~stall. On issue:
  - mem_rd_en=1, mem_addr=base+linear index.
  - col increments; on col wrap at input_x-1, col=0 and row increments.
  - After issuing the last pixel (row input_y-1, col input_x-1), go to DRAIN.
- DRAIN: no reads issued; wait for the last pixel to be emitted, then go to IDLE with busy=0.
- Pipeline: mem_rd_en at cycle t, data at t+1, registered output (output_valid, data_out) at t+2. Latency start-to-first-output_valid = 3 cycles with stall low.
- sof and eof are tags carried down the 2-stage pipeline with the read, not recomputed at output.
- Stall gates issue only. Up to 2 already-issued pixels still emerge after stall rises. output_valid has gaps; pixel order is never altered.
- Unstalled throughput: 1 pixel/cycle. A frame occupies input_x*input_y + 2 cycles after ISSUE entry.
- start while busy=1 is ignored, including start in the eof cycle (busy is still high then). Start is accepted again the cycle after busy falls.
- stall in IDLE or DRAIN has no effect.
- input_x=1 or input_y=1 must work: sof and eof coincide when both are 1.
- Address arithmetic: linear index counter, width addr_width, no wrap checking (caller guarantees range).
- Reset asserted mid-frame: stream aborts immediately. No eof or done is produced; the next start begins a fresh frame with sof.

Decomposition:
- No shared package; all constants are local parameters (TOTAL = input_x*input_y, state encodings).
- One natural sub-module: raster_counter (row/col/linear-index counter with enable, clear, last flag), reusable by the line-buffer controllers.

Test Plan:
- Basic 5x5, base_addr=100, memory[a]=a: pulse start -> mem_addr 100..124 on consecutive cycles; output_valid for 25 cycles starting 3 cycles after start; data_out 100..124; sof with 100; eof and done with 124; busy drops the cycle after.
- Stall mid-frame: stall high for 4 cycles after 7 reads -> exactly 2 more pixels (values 105,106) emerge, then a 4-cycle output_valid gap; stream resumes at 107 with no loss or duplication; 25 pixels total.
- start while busy: pulse start again at pixel 10 and on the eof cycle -> ignored, no extra frame. start the cycle after busy falls -> new frame, sof on first pixel.
- Reset mid-frame: rst at pixel 12 -> next cycle all outputs 0, no eof/done. New start with base_addr=0 -> clean 0..24 with sof.
- Degenerate input_x=1, input_y=1: start -> single output_valid with sof=eof=done=1 at cycle start+3.
- Back-to-back chained into a stride-2 line buffer (5x5): two frames -> line buffer output_valid count 4 per frame; windows match reference model.
